cnn_pcim_wr_ctrl: RTL and testbench

Sequences the 512-bit CNN result stream from the 64-to-512 width converter into AXI4 INCR write bursts on the PCIM master port, toward a host ring buffer. It generates AW/W/B traffic, ring addresses, wlast and per-burst accounting, and limits the number of outstanding writes. Software configures and monitors it through OCL registers; the OCL decode is outside this block.

---
 rtl/cnn_pcim_wr_ctrl.sv | 103 ++++++++++
 tb/tb_cnn_pcim_wr_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_pcim_wr_ctrl.sv
// cnn_pcim_wr_ctrl: turns the 512-bit CNN result stream into AXI4 INCR write bursts into a host ring buffer.
module cnn_pcim_wr_ctrl #(
  parameter int BURST_BEATS     = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int AXI_ID          = 0
) (
  input  logic          clk_main_a0,
  input  logic          rst_main_n,
  input  logic          cfg_enable,
  input  logic [63:0]   cfg_base_addr,
  input  logic [15:0]   cfg_num_bursts,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [511:0]  s_tdata,
  output logic [15:0]   awid,
  output logic [63:0]   awaddr,
  output logic [7:0]    awlen,
  output logic [2:0]    awsize,
  output logic          awvalid,
  input  logic          awready,
  output logic [511:0]  wdata,
  output logic [63:0]   wstrb,
  output logic          wlast,
  output logic          wvalid,
  input  logic          wready,
  input  logic [15:0]   bid,
  input  logic [1:0]    bresp,
  input  logic          bvalid,
  output logic          bready,
  output logic          busy,
  output logic [31:0]   bursts_done,
  output logic [15:0]   wr_ptr,
  output logic          err
);
  localparam int ALIGN = $clog2(BURST_BEATS * 64);
  localparam int BW    = $clog2(BURST_BEATS) + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state_q, state_d;
  logic [63:0]   awaddr_q, awaddr_d;
  logic [15:0]   wr_ptr_q, wr_ptr_d, num_eff;
  logic [3:0]    outst_q, outst_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [31:0]   done_q, done_d;
  logic          err_q, err_d;
  logic          start, aw_hs, w_hs, beat_last, b_ok, unused_bid;

  assign unused_bid = ^bid;
  assign num_eff    = cfg_num_bursts == 16'd0 ? 16'd1 : cfg_num_bursts;
  assign start      = state_q == IDLE && cfg_enable && s_tvalid && outst_q < 4'(MAX_OUTSTANDING);
  assign aw_hs      = state_q == ADDR && awready;
  assign w_hs       = state_q == DATA && s_tvalid && wready;
  assign beat_last  = beat_q == BW'(BURST_BEATS - 1);
  // A response with nothing outstanding is dropped rather than allowed to underflow the count.
  assign b_ok       = bvalid && outst_q != 4'd0;

  always_comb begin
    state_d  = start ? ADDR : aw_hs ? DATA : (w_hs && beat_last) ? IDLE : state_q;
    awaddr_d = start ? (cfg_base_addr & ~((64'd1 << ALIGN) - 64'd1)) + (64'(wr_ptr_q) << ALIGN) : awaddr_q;
    wr_ptr_d = !aw_hs ? wr_ptr_q : (17'(wr_ptr_q) + 17'd1 >= 17'(num_eff)) ? 16'd0 : wr_ptr_q + 16'd1;
    outst_d  = outst_q + 4'(aw_hs) - 4'(b_ok);
    beat_d   = !w_hs ? beat_q : beat_last ? '0 : beat_q + BW'(1);
    done_d   = done_q + 32'(b_ok);
    err_d    = err_q | (bvalid && (bresp != 2'b00 || !b_ok));
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q  <= IDLE;
      awaddr_q <= '0;
      wr_ptr_q <= '0;
      outst_q  <= '0;
      beat_q   <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      awaddr_q <= awaddr_d;
      wr_ptr_q <= wr_ptr_d;
      outst_q  <= outst_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign awid        = 16'(AXI_ID);
  assign awaddr      = awaddr_q;
  assign awlen       = 8'(BURST_BEATS - 1);
  assign awsize      = 3'h6;
  assign awvalid     = state_q == ADDR;
  assign wdata       = s_tdata;
  assign wstrb       = '1;
  assign wvalid      = state_q == DATA && s_tvalid;
  assign s_tready    = state_q == DATA && wready;
  assign wlast       = state_q == DATA && beat_last;
  assign bready      = 1'b1;
  assign busy        = state_q != IDLE || outst_q != 4'd0;
  assign bursts_done = done_q;
  assign wr_ptr      = wr_ptr_q;
  assign err         = err_q;
endmodule

// File: tb/tb_cnn_pcim_wr_ctrl.sv
// tb_cnn_pcim_wr_ctrl: directed scenario bench for the PCIM write burst controller.
module tb_cnn_pcim_wr_ctrl;
  logic         clk_main_a0 = 1'b0;
  logic         rst_main_n, cfg_enable;
  logic [63:0]  cfg_base_addr;
  logic [15:0]  cfg_num_bursts;
  logic         s_tvalid, s_tready;
  logic [511:0] s_tdata, wdata;
  logic [15:0]  awid, bid, wr_ptr;
  logic [63:0]  awaddr, wstrb;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid, awready, wlast, wvalid, wready;
  logic [1:0]   bresp;
  logic         bvalid, bready, busy, err;
  logic [31:0]  bursts_done, seq = 32'h100;
  int tests = 0;
  int fails = 0;

  cnn_pcim_wr_ctrl dut (
    .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n), .cfg_enable(cfg_enable),
    .cfg_base_addr(cfg_base_addr), .cfg_num_bursts(cfg_num_bursts),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .busy(busy), .bursts_done(bursts_done), .wr_ptr(wr_ptr), .err(err)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_main_n = 1'b0; cfg_enable = 1'b0; cfg_base_addr = '0; cfg_num_bursts = '0;
    s_tvalid = 1'b0; s_tdata = '0; awready = 1'b0; wready = 1'b0;
    bid = '0; bresp = '0; bvalid = 1'b0;
    repeat (2) @(negedge clk_main_a0);
    rst_main_n = 1'b1;
    #1;
  endtask

  task automatic send_b(input logic [1:0] resp);
    @(negedge clk_main_a0);
    bvalid = 1'b1; bresp = resp; bid = 16'h5a5a;
    @(negedge clk_main_a0);
    bvalid = 1'b0; bresp = 2'b00;
    #1;
  endtask

  // Drives one burst: waits for AW, optionally stalls it, then streams beats until wlast.
  task automatic run_burst(input int stall_aw, input bit toggle_w, input bit keep_valid,
                           input int dis_at, input int rst_at,
                           output logic [63:0] addr, output int beats, output int last_beat,
                           output int last_cnt, output int bad, output bit to);
    int n;
    bit done;
    logic [63:0] a0;
    beats = 0; last_beat = 0; last_cnt = 0; bad = 0; to = 1'b0; done = 1'b0; n = 0; addr = '0;
    s_tvalid = 1'b1; awready = 1'b0; wready = 1'b0;
    while (!awvalid && n < 50) begin
      @(negedge clk_main_a0); #1; n++;
    end
    if (!awvalid) begin
      to = 1'b1;
      return;
    end
    a0 = awaddr;
    for (int i = 0; i < stall_aw; i++) begin
      @(negedge clk_main_a0); #1;
      if (!awvalid || awaddr !== a0 || wvalid || s_tready) bad++;
    end
    awready = 1'b1; addr = awaddr;
    @(negedge clk_main_a0);
    awready = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      wready = toggle_w ? (c % 2 == 1) : 1'b1;
      s_tdata = {16{seq}};
      #1;
      if (s_tready !== wready) bad++;
      if (wvalid && wready) begin
        if (wdata !== {16{seq}}) bad++;
        beats++; seq++;
        if (wlast) begin
          last_cnt++; last_beat = beats; done = 1'b1;
        end
        if (dis_at == beats) cfg_enable = 1'b0;
        if (rst_at == beats) begin
          #2 rst_main_n = 1'b0;
          return;
        end
      end
      if (!done) @(negedge clk_main_a0);
    end
    if (!done) to = 1'b1;
    @(negedge clk_main_a0);
    s_tvalid = keep_valid; wready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_main_n = 1'b0; cfg_enable = 1'b1; s_tvalid = 1'b1; awready = 1'b1; wready = 1'b1;
    cfg_base_addr = 64'h1000; cfg_num_bursts = 16'd4; bvalid = 1'b0; bresp = '0; bid = '0; s_tdata = '0;
    repeat (2) @(negedge clk_main_a0);
    #1;
    tests++; if (awvalid !== 1'b0) begin fails++; $display("FAIL reset_awvalid got %b exp 0", awvalid); end
    tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL reset_wvalid got %b exp 0", wvalid); end
    tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_s_tready got %b exp 0", s_tready); end
    tests++; if (wlast !== 1'b0) begin fails++; $display("FAIL reset_wlast got %b exp 0", wlast); end
    tests++; if (awaddr !== 64'h0) begin fails++; $display("FAIL reset_awaddr got %h exp 0", awaddr); end
    tests++; if (wr_ptr !== 16'h0) begin fails++; $display("FAIL reset_wr_ptr got %h exp 0", wr_ptr); end
    tests++; if (bursts_done !== 32'h0) begin fails++; $display("FAIL reset_bursts_done got %h exp 0", bursts_done); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (bready !== 1'b1) begin fails++; $display("FAIL reset_bready got %b exp 1", bready); end
    tests++; if (wstrb !== {64{1'b1}}) begin fails++; $display("FAIL reset_wstrb got %h exp all ones", wstrb); end
  endtask

  task automatic test_single();
    logic [63:0] addr;
    int beats, lb, lc, bad;
    bit to;
    do_reset();
    cfg_base_addr = 64'h1000; cfg_num_bursts = 16'd4; cfg_enable = 1'b1;
    @(negedge clk_main_a0);
    s_tvalid = 1'b1;
    #1;
    tests++; if (awvalid !== 1'b0) begin fails++; $display("FAIL single_aw_early got %b exp 0", awvalid); end
    @(negedge clk_main_a0); #1;
    tests++; if (awvalid !== 1'b1) begin fails++; $display("FAIL single_aw_latency got %b exp 1", awvalid); end
    tests++; if (awaddr !== 64'h1000) begin fails++; $display("FAIL single_awaddr got %h exp 1000", awaddr); end
    tests++; if (awlen !== 8'd7) begin fails++; $display("FAIL single_awlen got %0d exp 7", awlen); end
    tests++; if (awsize !== 3'd6) begin fails++; $display("FAIL single_awsize got %0d exp 6", awsize); end
    tests++; if (awid !== 16'd0) begin fails++; $display("FAIL single_awid got %h exp 0", awid); end
    tests++; if (wvalid !== 1'b0) begin fails++; $display("FAIL single_w_before_aw got %b exp 0", wvalid); end
    run_burst(0, 1'b0, 1'b0, 0, 0, addr, beats, lb, lc, bad, to);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL single_timeout got %b exp 0", to); end
    tests++; if (beats !== 8) begin fails++; $display("FAIL single_beats got %0d exp 8", beats); end
    tests++; if (lb !== 8 || lc !== 1) begin fails++; $display("FAIL single_wlast got pos %0d cnt %0d exp pos 8 cnt 1", lb, lc); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL single_data got %0d errors exp 0", bad); end
    tests++; if (wr_ptr !== 16'd1) begin fails++; $display("FAIL single_wr_ptr got %0d exp 1", wr_ptr); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_pending got %b exp 1", busy); end
    tests++; if (bursts_done !== 32'd0) begin fails++; $display("FAIL single_done_pre got %0d exp 0", bursts_done); end
    send_b(2'b00);
    tests++; if (bursts_done !== 32'd1) begin fails++; $display("FAIL single_done got %0d exp 1", bursts_done); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end got %b exp 0", busy); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL single_err got %b exp 0", err); end
  endtask

  task automatic test_wrap();
    logic [63:0] addr;
    logic [63:0] ea [3];
    logic [15:0] ep [3];
    int beats, lb, lc, bad;
    bit to;
    ea = '{64'h1000, 64'h1200, 64'h1000};
    ep = '{16'd1, 16'd0, 16'd1};
    do_reset();
    cfg_base_addr = 64'h1000; cfg_num_bursts = 16'd2; cfg_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_burst(0, 1'b0, 1'b0, 0, 0, addr, beats, lb, lc, bad, to);
      tests++; if (addr !== ea[i] || to) begin fails++; $display("FAIL wrap_addr%0d got %h exp %h", i, addr, ea[i]); end
      tests++; if (wr_ptr !== ep[i]) begin fails++; $display("FAIL wrap_ptr%0d got %0d exp %0d", i, wr_ptr, ep[i]); end
      send_b(2'b00);
    end
    tests++; if (bursts_done !== 32'd3) begin fails++; $display("FAIL wrap_done got %0d exp 3", bursts_done); end
  endtask

  task automatic test_limit();
    logic [63:0] addr;
    int beats, lb, lc, bad, aw_cnt, rdy_cnt;
    bit to;
    do_reset();
    cfg_base_addr = 64'h1000; cfg_num_bursts = 16'd8; cfg_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_burst(i == 0 ? 5 : 0, 1'b1, 1'b1, 0, 0, addr, beats, lb, lc, bad, to);
      tests++; if (addr !== 64'h1000 + 64'(i) * 64'h200 || to) begin fails++; $display("FAIL limit_addr%0d got %h exp %h", i, addr, 64'h1000 + 64'(i) * 64'h200); end
      tests++; if (beats !== 8 || lc !== 1 || bad !== 0) begin fails++; $display("FAIL limit_burst%0d got beats %0d wlast %0d bad %0d exp 8 1 0", i, beats, lc, bad); end
    end
    aw_cnt = 0; rdy_cnt = 0;
    repeat (10) begin
      @(negedge clk_main_a0); #1;
      if (awvalid) aw_cnt++;
      if (s_tready || wvalid) rdy_cnt++;
    end
    tests++; if (aw_cnt !== 0) begin fails++; $display("FAIL limit_hold_aw got %0d cycles exp 0", aw_cnt); end
    tests++; if (rdy_cnt !== 0) begin fails++; $display("FAIL limit_hold_w got %0d cycles exp 0", rdy_cnt); end
    tests++; if (wr_ptr !== 16'd4 || busy !== 1'b1) begin fails++; $display("FAIL limit_state got ptr %0d busy %b exp 4 1", wr_ptr, busy); end
    send_b(2'b00);
    run_burst(0, 1'b1, 1'b0, 0, 0, addr, beats, lb, lc, bad, to);
    tests++; if (addr !== 64'h1800 || to) begin fails++; $display("FAIL limit_fifth_addr got %h exp 1800", addr); end
    repeat (4) send_b(2'b00);
    tests++; if (busy !== 1'b0 || bursts_done !== 32'd5) begin fails++; $display("FAIL limit_drain got busy %b done %0d exp 0 5", busy, bursts_done); end
  endtask

  task automatic test_error();
    logic [63:0] addr;
    logic [1:0] rs [3];
    logic ee [3];
    int beats, lb, lc, bad;
    bit to;
    rs = '{2'b00, 2'b10, 2'b00};
    ee = '{1'b0, 1'b1, 1'b1};
    do_reset();
    cfg_base_addr = 64'h2001FF; cfg_num_bursts = 16'd0; cfg_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_burst(0, 1'b0, 1'b0, 0, 0, addr, beats, lb, lc, bad, to);
      tests++; if (addr !== 64'h200000 || wr_ptr !== 16'd0 || to) begin fails++; $display("FAIL error_addr%0d got %h ptr %0d exp 200000 0", i, addr, wr_ptr); end
      send_b(rs[i]);
      tests++; if (err !== ee[i]) begin fails++; $display("FAIL error_err%0d got %b exp %b", i, err, ee[i]); end
    end
    tests++; if (bursts_done !== 32'd3) begin fails++; $display("FAIL error_done got %0d exp 3", bursts_done); end
  endtask

  task automatic test_disable();
    logic [63:0] addr;
    int beats, lb, lc, bad, aw_cnt;
    bit to;
    do_reset();
    cfg_base_addr = 64'h1000; cfg_num_bursts = 16'd4; cfg_enable = 1'b1;
    run_burst(0, 1'b0, 1'b1, 3, 0, addr, beats, lb, lc, bad, to);
    tests++; if (beats !== 8 || lb !== 8 || lc !== 1 || to) begin fails++; $display("FAIL disable_burst got beats %0d last %0d cnt %0d exp 8 8 1", beats, lb, lc); end
    aw_cnt = 0;
    repeat (10) begin
      @(negedge clk_main_a0); #1;
      if (awvalid) aw_cnt++;
    end
    tests++; if (aw_cnt !== 0) begin fails++; $display("FAIL disable_no_aw got %0d cycles exp 0", aw_cnt); end
    send_b(2'b00);
    tests++; if (busy !== 1'b0 || bursts_done !== 32'd1) begin fails++; $display("FAIL disable_end got busy %b done %0d exp 0 1", busy, bursts_done); end
    s_tvalid = 1'b0;
  endtask

  task automatic test_b_underflow();
    do_reset();
    send_b(2'b00);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL underflow_err got %b exp 1", err); end
    tests++; if (bursts_done !== 32'd0 || busy !== 1'b0) begin fails++; $display("FAIL underflow_count got done %0d busy %b exp 0 0", bursts_done, busy); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] addr;
    int beats, lb, lc, bad;
    bit to;
    do_reset();
    cfg_base_addr = 64'h1000; cfg_num_bursts = 16'd4; cfg_enable = 1'b1;
    run_burst(0, 1'b0, 1'b1, 0, 5, addr, beats, lb, lc, bad, to);
    #1;
    tests++; if (beats !== 5 || to) begin fails++; $display("FAIL rstmid_reach got %0d beats exp 5", beats); end
    tests++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || s_tready !== 1'b0 || wlast !== 1'b0) begin fails++; $display("FAIL rstmid_handshake got aw %b w %b rdy %b last %b exp 0", awvalid, wvalid, s_tready, wlast); end
    tests++; if (awaddr !== 64'h0 || wr_ptr !== 16'd0 || busy !== 1'b0 || bursts_done !== 32'd0) begin fails++; $display("FAIL rstmid_regs got addr %h ptr %0d busy %b done %0d exp 0", awaddr, wr_ptr, busy, bursts_done); end
    @(negedge clk_main_a0);
    rst_main_n = 1'b1;
    #1;
    tests++; if (wr_ptr !== 16'd0) begin fails++; $display("FAIL rstmid_ptr_release got %0d exp 0", wr_ptr); end
    run_burst(0, 1'b0, 1'b0, 0, 0, addr, beats, lb, lc, bad, to);
    tests++; if (addr !== 64'h1000 || to) begin fails++; $display("FAIL rstmid_addr got %h exp 1000", addr); end
    tests++; if (beats !== 8 || lc !== 1 || wr_ptr !== 16'd1) begin fails++; $display("FAIL rstmid_burst got beats %0d last %0d ptr %0d exp 8 1 1", beats, lc, wr_ptr); end
    send_b(2'b00);
    tests++; if (busy !== 1'b0 || bursts_done !== 32'd1) begin fails++; $display("FAIL rstmid_done got busy %b done %0d exp 0 1", busy, bursts_done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_limit();
    test_error();
    test_disable();
    test_b_underflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
